jtag_debug_sysclk_cmd_queue: RTL and testbench
==============================================

Name: jtag_debug_sysclk_cmd_queue

Overview:
Parametrised system-clock-side command stage for the Nios II JTAG debug module, successor to the fixed 38-bit sysclk decoder. It synchronises the virtual-JTAG update strobes into clk and captures the tck-domain shift register and IR. Captured commands go into a small FIFO so back-to-back JTAG updates are not lost while the core back-pressures. It then emits per-instruction one-hot take_action / take_no_action pulses alongside the held jdo word.

Parameters:
DR_WIDTH, 38, width of sr / jdo
IR_WIDTH, 2, width of ir_in; NUM_IR = 2**IR_WIDTH instruction codes
SYNC_STAGES, 2, synchroniser depth for vs_udr / vs_uir (legal 2..4)
QUEUE_DEPTH, 4, command FIFO entries (power of 2, >=2)
ACTION_BIT, 35, sr bit selecting action (1) vs no-action (0) pulse

Ports:
clk  in  1  system clock; the only clock
reset_n  in  1  asynchronous active-low reset
ir_in  in  IR_WIDTH  tck-domain IR, stable around update strobes
sr  in  DR_WIDTH  tck-domain shift register, stable around vs_udr
vs_udr  in  1  virtual update-DR level, async to clk
vs_uir  in  1  virtual update-IR level, async to clk
cmd_ready  in  1  core can accept a command this cycle
overflow_clr  in  1  clears sticky overflow
jdo  out  DR_WIDTH  data of last dispatched command, held
cmd_ir  out  IR_WIDTH  IR of last dispatched command, held
ir_last  out  IR_WIDTH  ir_in captured on last vs_uir edge
take_action  out  NUM_IR  one-cycle pulse, bit = command IR
take_no_action  out  NUM_IR  one-cycle pulse, bit = command IR
queue_level  out  clog2(QUEUE_DEPTH+1)  FIFO occupancy
overflow  out  1  sticky: a command was dropped

Behaviour:
- Reset (async assert, sync-release use): all outputs 0, FIFO empty, sync chains 0, startup counter loaded with SYNC_STAGES+1.
- Startup mask: while counter != 0, it decrements each clk and edge detection is suppressed. A strobe already high at reset release generates no command.
- Sync: each strobe passes through SYNC_STAGES flops, then one "prev" flop. Rising edge = synced & ~prev.
- uir edge: ir_last <= ir_in in the same clk. No enqueue.
- udr edge: push {ir_in, sr}, sampled in that cycle.
- Latency: vs_udr first sampled high at edge 0 → push at edge SYNC_STAGES+1. With the queue empty and cmd_ready=1, pop at edge SYNC_STAGES+2. Pulse, jdo and cmd_ir are valid in the following cycle. Total: pulse high after edge SYNC_STAGES+2.
- Dispatch: at each edge where queue is non-empty and cmd_ready=1, pop head:
  - jdo, cmd_ir <= entry.
  - If entry.sr[ACTION_BIT]=1, take_action[entry.ir]=1 for one cycle; otherwise take_no_action[entry.ir]=1.
  - Exactly one pulse bit per pop. All pulse bits are 0 in cycles with no pop. jdo and cmd_ir hold between pops.
- Back-pressure: cmd_ready=0 holds the queue. No pulses. Pushes still accepted.
- Full: a push with level==QUEUE_DEPTH and no same-cycle pop is dropped, and overflow <= 1. A push and pop in the same cycle when full are both accepted; level unchanged.
- Empty: no pop, no pulse.
- Same-cycle push+pop: level unchanged. An entry pushed in a cycle is never popped in that cycle.
- Pointer wrap is modulo QUEUE_DEPTH; queue_level is exact 0..QUEUE_DEPTH.
- overflow_clr clears overflow. If a drop occurs in the same cycle, overflow stays 1 (set wins).
- udr and uir edges in the same cycle are both serviced independently.
- Reset mid-operation discards queued commands and clears any in-flight pulse immediately.

Test Plan:
- Basic action: defaults; ir_in=2, sr[35]=1, sr[34:0]=0x123; pulse vs_udr; cmd_ready=1 → take_action=4'b0100 for exactly one cycle, 4 edges after first sample; jdo=0x8_0000_0123, cmd_ir=2; take_no_action=0.
- No-action decode: ir_in=0, sr[35]=0 → take_no_action=4'b0001 once; jdo updated; take_action stays 0.
- Back-pressure/overflow: cmd_ready=0; 5 udr pulses (ir 0..3, then 1) → queue_level=4, overflow=1, no pulses. Release cmd_ready → 4 consecutive single-cycle pulses for ir 0,1,2,3; 5th lost; level returns to 0.
- Full with simultaneous pop: level=4, cmd_ready=1; a push lands in the same cycle as a pop → no drop, overflow stays 0, level stays 4.
- Reset with vs_udr held high: release reset with vs_udr=1 → no push, level 0. Drop then raise vs_udr → exactly one command.
- uir and overflow_clr: vs_uir pulse with ir_in=3 → ir_last=3, level unchanged. overflow_clr asserted in the same cycle as a drop → overflow remains 1. Next clr alone → 0.

Source files
------------

// File: rtl/jtag_debug_sysclk_cmd_queue.sv
// System-clock side of the JTAG debug command path: synchronises the update strobes,
// queues captured {ir, sr} commands and dispatches one-hot action/no-action pulses.
module jtag_debug_sysclk_cmd_queue #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int ACTION_BIT  = 35,
  localparam int NUM_IR     = 2**IR_WIDTH,
  localparam int LVL_W      = $clog2(QUEUE_DEPTH+1),
  localparam int PTR_W      = $clog2(QUEUE_DEPTH),
  localparam int CNT_W      = $clog2(SYNC_STAGES+2)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [DR_WIDTH-1:0] sr,
  input  logic                vs_udr,
  input  logic                vs_uir,
  input  logic                cmd_ready,
  input  logic                overflow_clr,
  output logic [DR_WIDTH-1:0] jdo,
  output logic [IR_WIDTH-1:0] cmd_ir,
  output logic [IR_WIDTH-1:0] ir_last,
  output logic [NUM_IR-1:0]   take_action,
  output logic [NUM_IR-1:0]   take_no_action,
  output logic [LVL_W-1:0]    queue_level,
  output logic                overflow
);

  logic [SYNC_STAGES-1:0] r_udr_sync, r_uir_sync;
  logic                   r_udr_prev, r_uir_prev;
  logic                   r_udr_edge, r_uir_edge;
  logic [CNT_W-1:0]       r_start_cnt;

  logic [DR_WIDTH-1:0]    r_mem_dr [QUEUE_DEPTH];
  logic [IR_WIDTH-1:0]    r_mem_ir [QUEUE_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]       r_level;

  logic [DR_WIDTH-1:0]    r_jdo;
  logic [IR_WIDTH-1:0]    r_cmd_ir, r_ir_last;
  logic [NUM_IR-1:0]      r_take_action, r_take_no_action;
  logic                   r_overflow;

  logic                   w_mask_done;
  logic                   w_push, w_pop, w_full, w_wr, w_drop;
  logic [DR_WIDTH-1:0]    w_head_dr;
  logic [IR_WIDTH-1:0]    w_head_ir;
  logic [NUM_IR-1:0]      w_onehot;

  assign w_mask_done = (r_start_cnt == '0);

  // Edges are registered before use, so a strobe sampled at edge 0 pushes at edge SYNC_STAGES+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync  <= '0;
      r_uir_sync  <= '0;
      r_udr_prev  <= 1'b0;
      r_uir_prev  <= 1'b0;
      r_udr_edge  <= 1'b0;
      r_uir_edge  <= 1'b0;
      r_start_cnt <= CNT_W'(SYNC_STAGES+1);
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
      r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
      r_udr_edge <= w_mask_done & r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
      r_uir_edge <= w_mask_done & r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;
      if (!w_mask_done) r_start_cnt <= r_start_cnt - CNT_W'(1);
    end
  end

  assign w_push    = r_udr_edge;
  assign w_pop     = (r_level != '0) & cmd_ready;
  assign w_full    = (r_level == LVL_W'(QUEUE_DEPTH));
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_head_dr = r_mem_dr[r_rd_ptr];
  assign w_head_ir = r_mem_ir[r_rd_ptr];
  assign w_onehot  = NUM_IR'(1) << w_head_ir;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_dr[r_wr_ptr] <= sr;
      r_mem_ir[r_wr_ptr] <= ir_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_wr && w_pop) r_level <= r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jdo            <= '0;
      r_cmd_ir         <= '0;
      r_ir_last        <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_overflow       <= 1'b0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      if (w_pop) begin
        r_jdo    <= w_head_dr;
        r_cmd_ir <= w_head_ir;
        if (w_head_dr[ACTION_BIT]) r_take_action    <= w_onehot;
        else                       r_take_no_action <= w_onehot;
      end
      if (r_uir_edge) r_ir_last <= ir_in;
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  assign jdo            = r_jdo;
  assign cmd_ir         = r_cmd_ir;
  assign ir_last        = r_ir_last;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign queue_level    = r_level;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_jtag_debug_sysclk_cmd_queue.sv
// Bench for jtag_debug_sysclk_cmd_queue: directed scenarios plus a randomized run
// against a queue-based reference model of the command path.
module tb_jtag_debug_sysclk_cmd_queue;

  localparam int DR  = 38;
  localparam int IRW = 2;
  localparam int NIR = 4;
  localparam int SS  = 2;
  localparam int QD  = 4;
  localparam int AB  = 35;
  localparam int LW  = 3;

  typedef struct packed {
    logic [IRW-1:0] ir;
    logic [DR-1:0]  dr;
  } cmd_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [IRW-1:0] ir_in;
  logic [DR-1:0]  sr;
  logic           vs_udr, vs_uir, cmd_ready, overflow_clr;
  logic [DR-1:0]  jdo;
  logic [IRW-1:0] cmd_ir, ir_last;
  logic [NIR-1:0] take_action, take_no_action;
  logic [LW-1:0]  queue_level;
  logic           overflow;

  jtag_debug_sysclk_cmd_queue #(
    .DR_WIDTH(DR), .IR_WIDTH(IRW), .SYNC_STAGES(SS), .QUEUE_DEPTH(QD), .ACTION_BIT(AB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready), .overflow_clr(overflow_clr),
    .jdo(jdo), .cmd_ir(cmd_ir), .ir_last(ir_last),
    .take_action(take_action), .take_no_action(take_no_action),
    .queue_level(queue_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit pulse_seen;

  // Reference model: a strobe rising edge becomes a command SS+1 edges later.
  cmd_t           mq[$];
  int             pend_udr[$], pend_uir[$];
  bit             p_udr, p_uir;
  logic [DR-1:0]  m_jdo;
  logic [IRW-1:0] m_cmd_ir, m_ir_last;
  logic [NIR-1:0] m_ta, m_tna;
  bit             m_ovf;

  function automatic void model_reset();
    mq.delete(); pend_udr.delete(); pend_uir.delete();
    p_udr = vs_udr; p_uir = vs_uir;
    m_jdo = '0; m_cmd_ir = '0; m_ir_last = '0; m_ta = '0; m_tna = '0; m_ovf = 1'b0;
  endfunction

  function automatic void model_step();
    bit   pop, push, drop;
    cmd_t e;
    if (!reset_n) begin
      model_reset();
      return;
    end
    pop  = (mq.size() != 0) && cmd_ready;
    push = (pend_udr.size() != 0) && (pend_udr[0] == cyc);
    if (push) void'(pend_udr.pop_front());
    m_ta = '0; m_tna = '0;
    if (pop) begin
      e = mq.pop_front();
      m_jdo = e.dr; m_cmd_ir = e.ir;
      if (e.dr[AB]) m_ta[e.ir] = 1'b1;
      else          m_tna[e.ir] = 1'b1;
    end
    drop = 1'b0;
    if (push) begin
      if (mq.size() < QD) begin
        e = {ir_in, sr};
        mq.push_back(e);
      end else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    if ((pend_uir.size() != 0) && (pend_uir[0] == cyc)) begin
      void'(pend_uir.pop_front());
      m_ir_last = ir_in;
    end
    if (vs_udr && !p_udr) pend_udr.push_back(cyc + SS + 1);
    if (vs_uir && !p_uir) pend_uir.push_back(cyc + SS + 1);
    p_udr = vs_udr; p_uir = vs_uir;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    if ((take_action | take_no_action) != '0) pulse_seen = 1'b1;
  endtask

  task automatic udr_pulse(input logic [IRW-1:0] ir, input logic [DR-1:0] d);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    tick(); tick();
    vs_udr = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 0; vs_uir = 0; cmd_ready = 0; overflow_clr = 0;
    model_reset();
    tick(); tick(); tick();
    total++;
    if ({jdo, cmd_ir, ir_last, take_action, take_no_action, queue_level, overflow} !== '0) begin
      bad++; $display("FAIL reset_outputs got jdo=%h lvl=%0d ovf=%b exp all zero", jdo, queue_level, overflow);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (queue_level !== 0 || take_action !== 0 || take_no_action !== 0) begin
      bad++; $display("FAIL reset_release got lvl=%0d ta=%b tna=%b exp 0", queue_level, take_action, take_no_action);
    end
  endtask

  task automatic test_basic_action();
    logic [NIR-1:0] exp_ta;
    cmd_ready = 1'b1; ir_in = 2'd2; sr = 38'h08_0000_0123; vs_udr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 1) vs_udr = 1'b0;
      exp_ta = (i == 4) ? 4'b0100 : 4'b0000;
      total++;
      if (take_action !== exp_ta) begin
        bad++; $display("FAIL basic_ta edge=%0d got=%b exp=%b", i, take_action, exp_ta);
      end
      total++;
      if (take_no_action !== 4'b0000) begin
        bad++; $display("FAIL basic_tna edge=%0d got=%b exp=0000", i, take_no_action);
      end
    end
    total++;
    if (jdo !== 38'h08_0000_0123 || cmd_ir !== 2'd2) begin
      bad++; $display("FAIL basic_jdo got jdo=%h ir=%0d exp jdo=0800000123 ir=2", jdo, cmd_ir);
    end
  endtask

  task automatic test_no_action();
    logic [DR-1:0] d;
    int n_tna = 0, n_ta = 0;
    d = {6'($urandom), $urandom};
    d[AB] = 1'b0;
    cmd_ready = 1'b1;
    ir_in = 2'd0; sr = d; vs_udr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) vs_udr = 1'b0;
      if (take_no_action == 4'b0001) n_tna++;
      if (take_action != 0) n_ta++;
    end
    total++;
    if (n_tna !== 1 || n_ta !== 0) begin
      bad++; $display("FAIL noact_pulses got tna=%0d ta=%0d exp tna=1 ta=0", n_tna, n_ta);
    end
    total++;
    if (jdo !== d) begin
      bad++; $display("FAIL noact_jdo got=%h exp=%h", jdo, d);
    end
  endtask

  task automatic test_backpressure();
    logic [IRW-1:0] irs [5];
    logic [DR-1:0]  ds  [5];
    logic [NIR-1:0] onehot;
    irs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    cmd_ready = 1'b0; pulse_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ds[k] = {6'($urandom), $urandom};
      udr_pulse(irs[k], ds[k]);
    end
    total++;
    if (queue_level !== 3'd4 || overflow !== 1'b1 || pulse_seen) begin
      bad++; $display("FAIL bp_hold got lvl=%0d ovf=%b pulse=%b exp lvl=4 ovf=1 pulse=0", queue_level, overflow, pulse_seen);
    end
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      onehot = 4'b0001 << irs[k];
      total++;
      if (take_action !== (ds[k][AB] ? onehot : 4'b0) || take_no_action !== (ds[k][AB] ? 4'b0 : onehot)) begin
        bad++; $display("FAIL bp_drain k=%0d got ta=%b tna=%b exp onehot=%b act=%b", k, take_action, take_no_action, onehot, ds[k][AB]);
      end
      total++;
      if (jdo !== ds[k] || cmd_ir !== irs[k]) begin
        bad++; $display("FAIL bp_jdo k=%0d got=%h/%0d exp=%h/%0d", k, jdo, cmd_ir, ds[k], irs[k]);
      end
    end
    tick();
    total++;
    if (queue_level !== 0 || take_action !== 0 || take_no_action !== 0) begin
      bad++; $display("FAIL bp_empty got lvl=%0d ta=%b tna=%b exp 0", queue_level, take_action, take_no_action);
    end
  endtask

  task automatic test_full_simultaneous();
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL full_clr got=%b exp=0", overflow);
    end
    cmd_ready = 1'b0;
    for (int k = 0; k < 4; k++) udr_pulse(IRW'(k), {6'($urandom), $urandom});
    total++;
    if (queue_level !== 3'd4) begin
      bad++; $display("FAIL full_level got=%0d exp=4", queue_level);
    end
    ir_in = 2'd1; sr = {6'($urandom), $urandom}; vs_udr = 1'b1;
    tick(); tick(); vs_udr = 1'b0; tick();
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    total++;
    if (queue_level !== 3'd4 || overflow !== 1'b0 || cmd_ir !== 2'd0) begin
      bad++; $display("FAIL full_pushpop got lvl=%0d ovf=%b ir=%0d exp lvl=4 ovf=0 ir=0", queue_level, overflow, cmd_ir);
    end
    cmd_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      total++;
      if (cmd_ir !== ((k == 4) ? 2'd1 : IRW'(k))) begin
        bad++; $display("FAIL full_order k=%0d got=%0d", k, cmd_ir);
      end
    end
    tick();
  endtask

  task automatic test_uir_clr();
    logic [LW-1:0] lvl0;
    lvl0 = queue_level;
    ir_in = 2'd3; vs_uir = 1'b1; tick(); tick(); vs_uir = 1'b0;
    tick(); tick(); tick();
    ir_in = 2'd0;
    total++;
    if (ir_last !== 2'd3 || queue_level !== lvl0) begin
      bad++; $display("FAIL uir got ir_last=%0d lvl=%0d exp 3/%0d", ir_last, queue_level, lvl0);
    end
    cmd_ready = 1'b0;
    for (int k = 0; k < 4; k++) udr_pulse(IRW'(k), {6'($urandom), $urandom});
    ir_in = 2'd2; vs_udr = 1'b1; tick(); tick(); vs_udr = 1'b0; tick();
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL clr_vs_drop got=%b exp=1", overflow);
    end
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL clr_alone got=%b exp=0", overflow);
    end
    cmd_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    total++;
    if (queue_level !== 0) begin
      bad++; $display("FAIL uir_drain got=%0d exp=0", queue_level);
    end
  endtask

  task automatic test_reset_udr_high();
    cmd_ready = 1'b0;
    udr_pulse(2'd1, 38'h08_0000_0001);
    udr_pulse(2'd2, 38'h00_0000_0002);
    cmd_ready = 1'b1; tick();
    reset_n = 1'b0; vs_udr = 1'b1; model_reset();
    #1;
    total++;
    if (queue_level !== 0 || take_action !== 0 || take_no_action !== 0 || jdo !== 0) begin
      bad++; $display("FAIL midreset got lvl=%0d ta=%b tna=%b jdo=%h exp 0", queue_level, take_action, take_no_action, jdo);
    end
    tick(); tick(); tick();
    cmd_ready = 1'b0; reset_n = 1'b1; pulse_seen = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (queue_level !== 0 || pulse_seen) begin
      bad++; $display("FAIL udr_high_release got lvl=%0d pulse=%b exp 0", queue_level, pulse_seen);
    end
    vs_udr = 1'b0; tick(); tick();
    vs_udr = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (queue_level !== 3'd1) begin
      bad++; $display("FAIL udr_high_rise got=%0d exp=1", queue_level);
    end
    vs_udr = 1'b0; cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      vs_udr       = 1'($urandom_range(0, 1));
      vs_uir       = ($urandom_range(0, 5) == 0);
      ir_in        = IRW'($urandom);
      sr           = {6'($urandom), $urandom};
      cmd_ready    = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      overflow_clr = ($urandom_range(0, 15) == 0);
      tick();
      total++;
      if (queue_level !== LW'(mq.size())) begin
        bad++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, queue_level, mq.size());
      end
      total++;
      if (take_action !== m_ta || take_no_action !== m_tna) begin
        bad++; $display("FAIL rand_pulse cyc=%0d got=%b/%b exp=%b/%b", cyc, take_action, take_no_action, m_ta, m_tna);
      end
      total++;
      if (jdo !== m_jdo || cmd_ir !== m_cmd_ir) begin
        bad++; $display("FAIL rand_jdo cyc=%0d got=%h/%0d exp=%h/%0d", cyc, jdo, cmd_ir, m_jdo, m_cmd_ir);
      end
      total++;
      if (overflow !== m_ovf) begin
        bad++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
      end
      total++;
      if (ir_last !== m_ir_last) begin
        bad++; $display("FAIL rand_ir_last cyc=%0d got=%0d exp=%0d", cyc, ir_last, m_ir_last);
      end
    end
    vs_udr = 1'b0; vs_uir = 1'b0; overflow_clr = 1'b0; cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (queue_level !== 0 || mq.size() != 0) begin
      bad++; $display("FAIL rand_drain got=%0d model=%0d exp=0", queue_level, mq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_action();
    test_no_action();
    test_backpressure();
    test_full_simultaneous();
    test_uir_clr();
    test_reset_udr_high();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
